// File: rtl/register_file_pkg.sv
// Shared processor constants: datapath width, register address width and the
// hard-wired zero register index, also used by the ALU-source mux and control unit.
package register_file_pkg;

   localparam int RF_WIDTH    = 16;
   localparam int RF_ADDR_W   = 4;
   localparam int RF_ZERO_REG = 0;

endpackage

// File: rtl/register_file_if.sv
// Register file access bus: one write port and two registered read ports.
interface register_file_if
   import register_file_pkg::*;
#(
   parameter int WIDTH  = RF_WIDTH,
   parameter int ADDR_W = RF_ADDR_W
) ();

   logic              RegWrite;
   logic [ADDR_W-1:0] WriteReg;
   logic [WIDTH-1:0]  WriteData;
   logic [ADDR_W-1:0] ReadReg1;
   logic [ADDR_W-1:0] ReadReg2;
   logic [WIDTH-1:0]  ReadData1;
   logic [WIDTH-1:0]  ReadData2;

   modport master (
      output RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
      input  ReadData1, ReadData2
   );

   modport slave (
      input  RegWrite, WriteReg, WriteData, ReadReg1, ReadReg2,
      output ReadData1, ReadData2
   );

endinterface

// File: rtl/register_file.sv
// 2**ADDR_W x WIDTH register file with a hard-wired zero register, one write port
// and two registered, write-first read ports.
module register_file
   import register_file_pkg::*;
#(
   parameter int WIDTH  = RF_WIDTH,
   parameter int ADDR_W = RF_ADDR_W
)
(
   input logic            CLK,
   input logic            Reset,
   register_file_if.slave bus
);

   localparam int                DEPTH     = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(RF_ZERO_REG);

   logic [WIDTH-1:0] r_regs [DEPTH];
   logic [WIDTH-1:0] r_rd1;
   logic [WIDTH-1:0] r_rd2;
   logic             w_wr_en;
   logic [WIDTH-1:0] w_rd1;
   logic [WIDTH-1:0] w_rd2;

   assign w_wr_en = bus.RegWrite && (bus.WriteReg != ZERO_ADDR);

   // Write-first: a same-edge write to the addressed register wins over stored data.
   function automatic logic [WIDTH-1:0] read_sel(input logic [ADDR_W-1:0] addr);
      if (addr == ZERO_ADDR)
         return '0;
      else if (w_wr_en && (bus.WriteReg == addr))
         return bus.WriteData;
      else
         return r_regs[addr];
   endfunction

   always_comb begin
      w_rd1 = read_sel(bus.ReadReg1);
      w_rd2 = read_sel(bus.ReadReg2);
   end

   // Entry 0 is never written, so it stays at its reset value.
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < DEPTH; i++)
            r_regs[i] <= '0;
      end else if (w_wr_en) begin
         r_regs[bus.WriteReg] <= bus.WriteData;
      end
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_rd1 <= '0;
         r_rd2 <= '0;
      end else begin
         r_rd1 <= w_rd1;
         r_rd2 <= w_rd2;
      end
   end

   assign bus.ReadData1 = r_rd1;
   assign bus.ReadData2 = r_rd2;

endmodule

// File: tb/tb_register_file.sv
// Randomized and directed bench for register_file against an array-based model
// of the register contents with write-first read semantics.
module tb_register_file;
   import register_file_pkg::*;

   localparam int W     = RF_WIDTH;
   localparam int AW    = RF_ADDR_W;
   localparam int DEPTH = 2**AW;

   logic CLK;
   logic Reset;

   register_file_if #(.WIDTH(W), .ADDR_W(AW)) bus ();

   register_file #(.WIDTH(W), .ADDR_W(AW)) dut (
      .CLK   (CLK),
      .Reset (Reset),
      .bus   (bus)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [W-1:0] mem [DEPTH];
   logic [W-1:0] exp1;
   logic [W-1:0] exp2;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic logic [W-1:0] model_read(input logic [AW-1:0] a);
      if (a == '0) return '0;
      if (bus.RegWrite && (bus.WriteReg == a)) return bus.WriteData;
      return mem[a];
   endfunction

   task automatic clear_model();
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
   endtask

   task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                        input logic [AW-1:0] a1, input logic [AW-1:0] a2);
      bus.RegWrite  = we;
      bus.WriteReg  = wa;
      bus.WriteData = wd;
      bus.ReadReg1  = a1;
      bus.ReadReg2  = a2;
   endtask

   // Predict outputs for the coming edge, commit the write to the model, then
   // advance to just after the edge.
   task automatic cycle();
      exp1 = model_read(bus.ReadReg1);
      exp2 = model_read(bus.ReadReg2);
      if (bus.RegWrite && (bus.WriteReg != '0)) mem[bus.WriteReg] = bus.WriteData;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      clear_model();
      drive(1'b0, '0, '0, '0, '0);
      Reset = 1'b0;
      #1 Reset = 1'b1;
      #1;
      n_checks++;
      if (bus.ReadData1 !== '0 || bus.ReadData2 !== '0) begin
         n_fail++;
         $display("FAIL reset_init got %h/%h expected 0000/0000", bus.ReadData1, bus.ReadData2);
      end
      drive(1'b1, 4'd4, 16'h4444, 4'd4, 4'd0);
      @(posedge CLK);
      #1;
      n_checks++;
      if (bus.ReadData1 !== '0) begin
         n_fail++;
         $display("FAIL reset_held got %h expected 0000", bus.ReadData1);
      end
      #3 Reset = 1'b0;
      cycle();
      n_checks++;
      if (bus.ReadData1 !== exp1) begin
         n_fail++;
         $display("FAIL first_write_after_reset got %h expected %h", bus.ReadData1, exp1);
      end
      drive(1'b1, 4'd5, 16'h1234, 4'd0, 4'd0);
      cycle();
      drive(1'b0, 4'd0, 16'h0000, 4'd5, 4'd5);
      cycle();
      n_checks++;
      if (bus.ReadData1 !== exp1 || bus.ReadData2 !== exp2) begin
         n_fail++;
         $display("FAIL preload_r5 got %h/%h expected %h/%h", bus.ReadData1, bus.ReadData2, exp1, exp2);
      end
      #3;
      drive(1'b1, 4'd5, 16'hAAAA, 4'd5, 4'd5);
      Reset = 1'b1;
      clear_model();
      #1;
      n_checks++;
      if (bus.ReadData1 !== '0 || bus.ReadData2 !== '0) begin
         n_fail++;
         $display("FAIL reset_async got %h/%h expected 0000/0000", bus.ReadData1, bus.ReadData2);
      end
      @(posedge CLK);
      #3;
      Reset = 1'b0;
      drive(1'b0, 4'd0, 16'h0000, 4'd5, 4'd4);
      cycle();
      n_checks++;
      if (bus.ReadData1 !== exp1 || bus.ReadData2 !== exp2 || exp1 !== 16'h0000) begin
         n_fail++;
         $display("FAIL r5_after_reset got %h/%h expected %h/%h", bus.ReadData1, bus.ReadData2, exp1, exp2);
      end
   endtask

   task automatic test_write_read();
      drive(1'b1, 4'd3, 16'hBEEF, 4'd0, 4'd0);
      cycle();
      drive(1'b0, 4'd0, 16'h0000, 4'd3, 4'd3);
      cycle();
      n_checks++;
      if (bus.ReadData1 !== 16'hBEEF || bus.ReadData2 !== 16'hBEEF) begin
         n_fail++;
         $display("FAIL write_read_r3 got %h/%h expected beef/beef", bus.ReadData1, bus.ReadData2);
      end
   endtask

   task automatic test_zero_reg();
      drive(1'b1, 4'd0, 16'hFFFF, 4'd0, 4'd3);
      cycle();
      n_checks++;
      if (bus.ReadData1 !== 16'h0000 || bus.ReadData2 !== exp2) begin
         n_fail++;
         $display("FAIL zero_bypass got %h/%h expected 0000/%h", bus.ReadData1, bus.ReadData2, exp2);
      end
      drive(1'b0, 4'd0, 16'h0000, 4'd0, 4'd0);
      cycle();
      n_checks++;
      if (bus.ReadData1 !== 16'h0000 || bus.ReadData2 !== 16'h0000) begin
         n_fail++;
         $display("FAIL zero_read got %h/%h expected 0000/0000", bus.ReadData1, bus.ReadData2);
      end
   endtask

   task automatic test_bypass();
      drive(1'b1, 4'd7, 16'h0001, 4'd0, 4'd0);
      cycle();
      drive(1'b1, 4'd6, 16'h0606, 4'd0, 4'd0);
      cycle();
      drive(1'b1, 4'd7, 16'h00A5, 4'd6, 4'd7);
      cycle();
      n_checks++;
      if (bus.ReadData2 !== 16'h00A5 || bus.ReadData1 !== exp1) begin
         n_fail++;
         $display("FAIL bypass_r7 got %h/%h expected %h/00a5", bus.ReadData1, bus.ReadData2, exp1);
      end
      drive(1'b1, 4'd7, 16'hC3C3, 4'd7, 4'd7);
      cycle();
      n_checks++;
      if (bus.ReadData1 !== exp1 || bus.ReadData2 !== exp2) begin
         n_fail++;
         $display("FAIL bypass_both got %h/%h expected %h/%h", bus.ReadData1, bus.ReadData2, exp1, exp2);
      end
   endtask

   task automatic test_no_write();
      drive(1'b1, 4'd9, 16'h2710, 4'd0, 4'd0);
      cycle();
      drive(1'b0, 4'd9, 16'h5555, 4'd9, 4'd0);
      cycle();
      n_checks++;
      if (bus.ReadData1 !== 16'h2710) begin
         n_fail++;
         $display("FAIL no_write_same got %h expected 2710", bus.ReadData1);
      end
      drive(1'b0, 4'd0, 16'h0000, 4'd0, 4'd9);
      cycle();
      n_checks++;
      if (bus.ReadData2 !== 16'h2710) begin
         n_fail++;
         $display("FAIL no_write_later got %h expected 2710", bus.ReadData2);
      end
   endtask

   task automatic test_hold();
      drive(1'b0, 4'd0, 16'h0000, 4'd3, 4'd9);
      cycle();
      #2;
      drive(1'b1, 4'd3, 16'h7777, 4'd7, 4'd5);
      #2;
      n_checks++;
      if (bus.ReadData1 !== exp1 || bus.ReadData2 !== exp2) begin
         n_fail++;
         $display("FAIL hold got %h/%h expected %h/%h", bus.ReadData1, bus.ReadData2, exp1, exp2);
      end
      drive(1'b0, 4'd0, 16'h0000, 4'd0, 4'd0);
      cycle();
   endtask

   task automatic test_all_regs();
      for (int i = 1; i < DEPTH; i++) begin
         drive(1'b1, AW'(i), W'(i * 16'h1111), 4'd0, 4'd0);
         cycle();
      end
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b0, 4'd0, 16'h0000, AW'(i), AW'(DEPTH - 1 - i));
         cycle();
         n_checks++;
         if (bus.ReadData1 !== W'(i * 16'h1111) || bus.ReadData2 !== W'((DEPTH - 1 - i) * 16'h1111)) begin
            n_fail++;
            $display("FAIL all_regs[%0d] got %h/%h expected %h/%h", i, bus.ReadData1, bus.ReadData2,
                     W'(i * 16'h1111), W'((DEPTH - 1 - i) * 16'h1111));
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 4'd11, W'($urandom), 4'd11, 4'd11);
         cycle();
         n_checks++;
         if (bus.ReadData1 !== exp1 || bus.ReadData2 !== exp2) begin
            n_fail++;
            $display("FAIL back_to_back[%0d] got %h/%h expected %h/%h", i, bus.ReadData1, bus.ReadData2, exp1, exp2);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom), AW'($urandom), W'($urandom), AW'($urandom), AW'($urandom));
         cycle();
         n_checks++;
         if (bus.ReadData1 !== exp1 || bus.ReadData2 !== exp2) begin
            n_fail++;
            $display("FAIL random[%0d] got %h/%h expected %h/%h", i, bus.ReadData1, bus.ReadData2, exp1, exp2);
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_zero_reg();
      test_bypass();
      test_no_write();
      test_hold();
      test_all_regs();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter WIDTH, 16, data width of every register and data port.
REQ-002 Parameter ADDR_W, 4, register address width; depth = 2**ADDR_W = 16 registers.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high; clears all state immediately on assertion.
REQ-005 RegWrite  input  1  write enable for the write port.
REQ-006 WriteReg  input  ADDR_W  write address.
REQ-007 WriteData  input  WIDTH  write data.
REQ-008 ReadReg1  input  ADDR_W  read port 1 address.
REQ-009 ReadReg2  input  ADDR_W  read port 2 address.
REQ-010 ReadData1  output  WIDTH  registered read port 1 data; feeds the ALU-source 4:1 select as operand A.
REQ-011 ReadData2  output  WIDTH  registered read port 2 data; feeds the ALU-source 4:1 select as operand B.

Function
REQ-012 Storage SHALL be 16 x WIDTH registers, r0..r15.
REQ-013 r0 SHALL read as 0 at all times; writes to address 0 SHALL be discarded.
REQ-014 On a rising CLK edge with RegWrite=1 and WriteReg!=0, r[WriteReg] SHALL take WriteData.
REQ-015 On a rising CLK edge with RegWrite=0, no register SHALL change.
REQ-016 ReadData1/ReadData2 SHALL be registered outputs: value on each rising edge = contents of r[ReadReg1]/r[ReadReg2] as sampled at that edge; latency 1 cycle from address to data.
REQ-017 Read-during-write bypass: if at an edge RegWrite=1, WriteReg!=0 and WriteReg==ReadRegN, ReadDataN SHALL take WriteData (write-first), not the old contents.
REQ-018 Bypass SHALL NOT apply when WriteReg==0; ReadDataN for address 0 SHALL be 0.
REQ-019 Both ports SHALL read the same address simultaneously with identical results, including under bypass.
REQ-020 Read addresses SHALL cause no side effects; ReadDataN SHALL hold between edges regardless of input changes.
REQ-021 Arithmetic: none; data passes unmodified, full WIDTH, no sign extension or truncation.

Reset
REQ-022 While Reset=1, r0..r15, ReadData1 and ReadData2 SHALL be 0, independent of CLK.
REQ-023 A write coincident with Reset assertion SHALL be lost; no register SHALL retain pre-reset data.
REQ-024 First write after Reset deassertion SHALL take effect on the first rising edge with Reset=0.

Structure
REQ-025 WIDTH default, ADDR_W default and the zero-register index SHALL be constants in the shared processor package, used also by the ALU-source mux and control unit.
REQ-026 No sub-module; storage, write decode and bypass SHALL be in register_file.

Verification
REQ-027 Reset with r5 preloaded 0x1234 -> assert Reset mid-cycle -> ReadData1/2=0 immediately; after release, read r5 -> 0x0000.
REQ-028 Write r3=0xBEEF (RegWrite=1), next cycle ReadReg1=3, ReadReg2=3 -> after one edge both outputs 0xBEEF.
REQ-029 Write r0=0xFFFF with ReadReg1=0 same edge -> ReadData1=0x0000; later read r0 -> 0x0000.
REQ-030 r7=0x0001, same edge write r7=0x00A5 with ReadReg2=7 -> ReadData2=0x00A5 (bypass); ReadReg1=6 unaffected.
REQ-031 RegWrite=0, WriteReg=9, WriteData=0x5555 -> r9 unchanged (reads previous 0x2710).
REQ-032 Write all r1..r15 with index*0x1111, read back all pairs (ReadReg1=i, ReadReg2=15-i) -> each output matches, no aliasing.
